// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle for the RV32M multiply/divide unit.
// Carries the start/flush request, operands and tag in; busy, done pulse, result and tag out.
// master = execute-stage/hazard side, slave = muldiv_unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            StartE;
   logic            FlushE;
   logic [2:0]      MulDivOpE;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic [4:0]      RdE;
   logic            BusyE;
   logic            DoneM;
   logic [XLEN-1:0] ResultM;
   logic [4:0]      RdM;

   modport master (
      output StartE, FlushE, MulDivOpE, SrcAE, SrcBE, RdE,
      input  BusyE, DoneM, ResultM, RdM
   );

   modport slave (
      input  StartE, FlushE, MulDivOpE, SrcAE, SrcBE, RdE,
      output BusyE, DoneM, ResultM, RdM
   );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier plus radix-2 restoring divider, one op in flight.
// Latency: MUL_STAGES cycles for multiplies, XLEN+2 for divides, 2 for divide-by-zero/overflow.
// Backpressure: none; BusyE tells the hazard unit to stall, StartE outside IDLE is ignored.
// Ports: CLK, RESET (async active-low), bus (slave): StartE/FlushE/MulDivOpE/SrcAE/SrcBE/RdE in,
//        BusyE/DoneM/ResultM/RdM out.
module muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic           CLK,
   input  logic           RESET,
   muldiv_unit_if.slave   bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
   localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_STAGES - 2);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            sel_rem_q, sel_rem_d;
   logic [4:0]      tag_q, tag_d;       // tag of the op in flight; RdM only moves on completion
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rdm_q, rdm_d;

   logic            accept;
   assign accept = (state_q == S_IDLE) && bus.StartE && !bus.FlushE;

   // ---------------- multiply datapath ----------------
   // Sign-extending to 2*XLEN makes a plain unsigned multiply produce the
   // correct low 2*XLEN bits for every signedness combination.
   logic              a_sx, b_sx;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res_c, mul_tap;

   always_comb begin
      a_sx      = ((bus.MulDivOpE == 3'b001) || (bus.MulDivOpE == 3'b010)) && bus.SrcAE[XLEN-1];
      b_sx      = (bus.MulDivOpE == 3'b001) && bus.SrcBE[XLEN-1];
      prod      = {{XLEN{a_sx}}, bus.SrcAE} * {{XLEN{b_sx}}, bus.SrcBE};
      mul_res_c = (bus.MulDivOpE[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // The output register is the last multiply stage, so only MUL_STAGES-1
   // intermediate registers exist; with one stage the product goes straight to ResultM.
   generate
      if (MUL_STAGES > 1) begin : g_mpipe
         logic [XLEN-1:0] mpipe_q [MUL_STAGES-1];
         logic [XLEN-1:0] mpipe_d [MUL_STAGES-1];

         always_comb begin
            mpipe_d = mpipe_q;
            if (accept || (state_q == S_MUL)) begin
               mpipe_d[0] = mul_res_c;
               for (int i = 1; i < MUL_STAGES - 1; i++) begin
                  mpipe_d[i] = mpipe_q[i-1];
               end
            end
         end

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               for (int i = 0; i < MUL_STAGES - 1; i++) begin
                  mpipe_q[i] <= '0;
               end
            end else begin
               mpipe_q <= mpipe_d;
            end
         end

         assign mul_tap = mpipe_q[MUL_STAGES-2];
      end else begin : g_mcomb
         assign mul_tap = mul_res_c;
      end
   endgenerate

   // ---------------- divide datapath ----------------
   logic            div_signed, a_neg, b_neg, b_zero, ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   shifted;
   logic            ge;
   logic [XLEN-1:0] diff, rem_next, q_fix, r_fix;

   always_comb begin
      div_signed = !bus.MulDivOpE[0];
      a_neg      = div_signed && bus.SrcAE[XLEN-1];
      b_neg      = div_signed && bus.SrcBE[XLEN-1];
      a_mag      = a_neg ? -bus.SrcAE : bus.SrcAE;
      b_mag      = b_neg ? -bus.SrcBE : bus.SrcBE;
      b_zero     = (bus.SrcBE == '0);
      ovf        = div_signed && (bus.SrcAE == MOST_NEG) && (bus.SrcBE == '1);

      // One restoring step. shifted is XLEN+1 bits wide so a divisor with its
      // top bit set still compares correctly; when ge holds the difference is
      // below the divisor and fits in XLEN bits.
      shifted  = {rem_q, quo_q[XLEN-1]};
      ge       = (shifted >= {1'b0, dvsr_q});
      diff     = shifted[XLEN-1:0] - dvsr_q;
      rem_next = ge ? diff : shifted[XLEN-1:0];

      q_fix    = qneg_q ? -quo_q : quo_q;
      r_fix    = rneg_q ? -rem_q : rem_q;
   end

   // ---------------- control ----------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      sel_rem_d = sel_rem_q;
      tag_d     = tag_q;
      done_d    = 1'b0;
      result_d  = result_q;
      rdm_d     = rdm_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               tag_d = bus.RdE;
               cnt_d = '0;
               if (!bus.MulDivOpE[2]) begin
                  if (MUL_STAGES == 1) begin
                     result_d = mul_res_c;
                     rdm_d    = bus.RdE;
                     done_d   = 1'b1;
                  end else begin
                     state_d = S_MUL;
                  end
               end else begin
                  sel_rem_d = bus.MulDivOpE[1];
                  if (b_zero) begin
                     quo_d   = '1;
                     rem_d   = bus.SrcAE;   // raw dividend, sign already correct
                     qneg_d  = 1'b0;
                     rneg_d  = 1'b0;
                     state_d = S_FIX;
                  end else if (ovf) begin
                     quo_d   = MOST_NEG;
                     rem_d   = '0;
                     qneg_d  = 1'b0;
                     rneg_d  = 1'b0;
                     state_d = S_FIX;
                  end else begin
                     quo_d   = a_mag;
                     rem_d   = '0;
                     dvsr_d  = b_mag;
                     qneg_d  = a_neg ^ b_neg;
                     rneg_d  = a_neg;
                     state_d = S_DIV;
                  end
               end
            end
         end
         S_MUL: begin
            if (cnt_q == MUL_LAST) begin
               result_d = mul_tap;
               rdm_d    = tag_q;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DIV: begin
            quo_d = {quo_q[XLEN-2:0], ge};
            rem_d = rem_next;
            if (cnt_q == DIV_LAST) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FIX: begin
            result_d = sel_rem_q ? r_fix : q_fix;
            rdm_d    = tag_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush wins over start and over completion in the same cycle.
      if (bus.FlushE) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
         rdm_d    = rdm_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         sel_rem_q <= 1'b0;
         tag_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         rdm_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         sel_rem_q <= sel_rem_d;
         tag_q     <= tag_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         rdm_q     <= rdm_d;
      end
   end

   assign bus.BusyE   = busy_q;
   assign bus.DoneM   = done_q;
   assign bus.ResultM = result_q;
   assign bus.RdM     = rdm_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed ops push expected results into a scoreboard;
// a negedge monitor pops and checks on every DoneM pulse.
// Also checks BusyE profiles, flush behaviour and asynchronous reset.
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic CLK;
   logic RESET;
   int   cyc;
   int   tests;
   int   failed;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
      int          id;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_res;
   logic [4:0]  last_rd;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge CLK) begin
      if (RESET === 1'b1 && bus.DoneM === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_done: DoneM=1 at cycle %0d with ResultM=%h RdM=%0d, required no DoneM",
                     cyc, bus.ResultM, bus.RdM);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("op%0d_result", e.id), bus.ResultM, e.res);
            chk($sformatf("op%0d_rd", e.id), 32'(bus.RdM), 32'(e.rd));
            chk($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Issue one op in the current cycle (cycle 0), then follow it to its DoneM
   // cycle, checking BusyE in cycles 1..lat. Returns inside the DoneM cycle so
   // the next call is a back-to-back start.
   task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] res, input int lat);
      exp_t e;
      int   c0;
      int   busy_err;
      int   first_bad;
      logic first_val;
      c0        = cyc;
      busy_err  = 0;
      first_bad = -1;
      first_val = 1'b0;
      e.res = res; e.rd = rd; e.cyc = c0 + lat; e.id = id;
      sb.push_back(e);
      bus.MulDivOpE = op;
      bus.SrcAE     = a;
      bus.SrcBE     = b;
      bus.RdE       = rd;
      bus.StartE    = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         @(posedge CLK);
         #1;
         bus.StartE = 1'b0;
         @(negedge CLK);
         if (bus.BusyE !== (k < lat)) begin
            busy_err++;
            if (first_bad < 0) begin
               first_bad = k;
               first_val = bus.BusyE;
            end
         end
      end
      #1;
      tests++;
      if (busy_err != 0) begin
         failed++;
         $display("FAIL op%0d_busy: BusyE=%b in cycle %0d (%0d bad cycles), required 1 in cycles 1..%0d and 0 in %0d",
                  id, first_val, first_bad, busy_err, lat - 1, lat);
      end
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL op%0d_no_done: no DoneM by cycle %0d, required one", id, lat);
         sb.delete();
      end
      last_res = res;
      last_rd  = rd;
   endtask

   // Start a divide that is never expected to complete; returns in cycle n.
   task automatic start_div_silent(input int n);
      bus.MulDivOpE = 3'b100;
      bus.SrcAE     = 32'd1000;
      bus.SrcBE     = 32'd3;
      bus.RdE       = 5'd30;
      bus.StartE    = 1'b1;
      repeat (n) begin
         @(posedge CLK);
         #1;
         bus.StartE = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc           = 0;
      tests         = 0;
      failed        = 0;
      last_res      = '0;
      last_rd       = '0;
      RESET         = 1'b0;
      bus.StartE    = 1'b0;
      bus.FlushE    = 1'b0;
      bus.MulDivOpE = 3'b000;
      bus.SrcAE     = '0;
      bus.SrcBE     = '0;
      bus.RdE       = '0;

      #22;
      chk("reset_busy",   32'(bus.BusyE),   32'd0);
      chk("reset_done",   32'(bus.DoneM),   32'd0);
      chk("reset_result", bus.ResultM,      32'd0);
      chk("reset_rd",     32'(bus.RdM),     32'd0);
      #1;
      RESET = 1'b1;  // released mid-cycle; first op accepted on the next edge

      // multiplies
      run_op(1,  3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2);
      run_op(2,  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 2);
      run_op(3,  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 2);
      run_op(4,  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 2);
      run_op(5,  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 2);
      run_op(6,  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 2);

      // normal divides
      run_op(7,  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 34);
      run_op(8,  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 34);
      run_op(9,  3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        34);
      run_op(10, 3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         34);
      run_op(11, 3'b100, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 34);
      run_op(12, 3'b110, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         34);
      run_op(13, 3'b101, 32'hFFFF_FFFF, 32'h8000_0000, 5'd17, 32'd1,         34);
      run_op(14, 3'b111, 32'hFFFF_FFFF, 32'h8000_0000, 5'd18, 32'h7FFF_FFFF, 34);

      // special cases
      run_op(15, 3'b101, 32'h0000_1234, 32'd0,         5'd19, 32'hFFFF_FFFF, 2);
      run_op(16, 3'b110, 32'h0000_1234, 32'd0,         5'd20, 32'h0000_1234, 2);
      run_op(17, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 2);
      run_op(18, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 2);

      // flush in cycle 10 together with a start that must be ignored
      start_div_silent(10);
      chk("flush_busy_before", 32'(bus.BusyE), 32'd1);
      bus.FlushE    = 1'b1;
      bus.StartE    = 1'b1;
      bus.MulDivOpE = 3'b000;
      bus.SrcAE     = 32'd5;
      bus.SrcBE     = 32'd5;
      bus.RdE       = 5'd31;
      @(posedge CLK);
      #1;
      bus.FlushE = 1'b0;
      bus.StartE = 1'b0;
      @(negedge CLK);
      chk("flush_busy_after", 32'(bus.BusyE),   32'd0);
      chk("flush_done_after", 32'(bus.DoneM),   32'd0);
      chk("flush_result_kept", bus.ResultM,     last_res);
      chk("flush_rd_kept",    32'(bus.RdM),     32'(last_rd));
      #1;
      run_op(19, 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, 2);

      // asynchronous reset mid-divide
      start_div_silent(20);
      chk("rst_busy_before", 32'(bus.BusyE), 32'd1);
      RESET = 1'b0;
      #1;
      chk("rst_busy",   32'(bus.BusyE), 32'd0);
      chk("rst_done",   32'(bus.DoneM), 32'd0);
      chk("rst_result", bus.ResultM,    32'd0);
      chk("rst_rd",     32'(bus.RdM),   32'd0);
      @(posedge CLK);
      @(posedge CLK);
      #3;
      RESET = 1'b1;
      run_op(20, 3'b000, 32'd2, 32'd2, 5'd24, 32'd4, 2);

      // idle tail: any stray completion shows up in the monitor
      repeat (40) @(posedge CLK);
      #1;
      chk("final_busy", 32'(bus.BusyE), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
